mul_issue_stage: RTL and testbench

Pipelined issue/retire stage wrapped around the combinational signed/unsigned/mixed carry-save array multiplier. It accepts M-extension multiply requests over a valid/ready handshake and decodes each opcode into the multiplier's `sign`/`mix` controls. Operands are registered to drive the array, and the 2×SIZE product is captured and returned as a SIZE-bit result with its tag. Throughput is one operation per cycle, latency is two cycles, and full backpressure and flush are supported.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_pipe_reg.sv | 36 +++
 rtl/mul_issue_stage.sv | 115 +++++++++++
 tb/tb_mul_issue_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared opcode, control and decode definitions for the multiply
// issue stage.
//   mul_op_e   - the four M-extension multiply opcodes (2-bit encoding)
//   mul_ctrl_t - multiplier mode controls plus result-half select
//   mul_decode - opcode -> control mapping
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic sign;    // both operands signed
    logic mix;     // a signed, b unsigned
    logic hi_sel;  // return product[2*SIZE-1:SIZE] instead of the low half
  } mul_ctrl_t;

  localparam int CTRL_W = 3;

  // MUL only needs the low half, which is identical for every signedness,
  // so it uses the plain unsigned mode.
  function automatic mul_ctrl_t mul_decode(mul_op_e op);
    mul_ctrl_t c;
    c = '0;
    case (op)
      OP_MUL:    begin c.sign = 1'b0; c.mix = 1'b0; c.hi_sel = 1'b0; end
      OP_MULH:   begin c.sign = 1'b1; c.mix = 1'b0; c.hi_sel = 1'b1; end
      OP_MULHSU: begin c.sign = 1'b0; c.mix = 1'b1; c.hi_sel = 1'b1; end
      default:   begin c.sign = 1'b0; c.mix = 1'b0; c.hi_sel = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// mul_pipe_reg: one valid/data pipeline slice.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears valid and data)
//   clear      - synchronous kill of the valid bit (highest priority)
//   load       - capture d and set valid
//   drop       - clear valid when not loading (entry consumed downstream)
//   d          - next data
//   valid, q   - registered valid bit and data
// Data only changes on load, so downstream logic fed from q stays quiet
// while the slice is empty.
module mul_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      else if (drop) valid <= 1'b0;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/mul_issue_stage.sv
// mul_issue_stage: two-stage issue/retire wrapper around an external
// combinational multiplier.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous kill of both stages
//   req_valid/req_ready   - request handshake; req_op, req_a, req_b, req_tag
//   mul_a, mul_b          - registered operands to the multiplier
//   mul_sign, mul_mix     - registered mode controls to the multiplier
//   mul_y                 - 2*SIZE product returned by the multiplier
//   rsp_valid/rsp_ready   - response handshake; rsp_data, rsp_tag
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high. req_ready never looks at req_valid.
// rsp_valid, rsp_data and rsp_tag are held stable until the transfer occurs.
//
// S1 holds the decoded operands and drives the multiplier; S2 holds the
// selected product half. Latency is two edges, throughput one per cycle.
module mul_issue_stage
  import mul_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SIZE-1:0]   req_a,
  input  logic [SIZE-1:0]   req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [SIZE-1:0]   mul_a,
  output logic [SIZE-1:0]   mul_b,
  output logic              mul_sign,
  output logic              mul_mix,
  input  logic [2*SIZE-1:0] mul_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SIZE-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int S1_W = 2*SIZE + CTRL_W + TAG_W;
  localparam int S2_W = SIZE + TAG_W;

  logic              s1_valid;
  logic [S1_W-1:0]   s1_d;
  logic [S1_W-1:0]   s1_q;
  mul_ctrl_t         req_ctrl;
  mul_ctrl_t         s1_ctrl;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid;
  logic [S2_W-1:0]   s2_d;
  logic [S2_W-1:0]   s2_q;
  logic [SIZE-1:0]   sel_half;

  logic              s2_adv;
  logic              s1_load;
  logic              rsp_fire;

  assign s2_adv   = s1_valid & (~s2_valid | rsp_ready);
  // rst_n is folded in so the stage advertises no capacity while held in
  // reset; after release the empty pipeline reports ready immediately.
  assign req_ready = rst_n & ~flush & (~s1_valid | s2_adv);
  assign s1_load  = req_valid & req_ready;
  assign rsp_fire = s2_valid & rsp_ready;

  // ---------------- S1: operand register ----------------
  assign req_ctrl = mul_decode(mul_op_e'(req_op));
  assign s1_d     = {req_a, req_b, req_ctrl, req_tag};

  mul_pipe_reg #(.W(S1_W)) u_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (s1_load),
    .drop  (s2_adv),
    .d     (s1_d),
    .valid (s1_valid),
    .q     (s1_q)
  );

  assign mul_a    = s1_q[S1_W-1 -: SIZE];
  assign mul_b    = s1_q[S1_W-SIZE-1 -: SIZE];
  assign s1_ctrl  = mul_ctrl_t'(s1_q[TAG_W +: CTRL_W]);
  assign s1_tag   = s1_q[TAG_W-1:0];
  assign mul_sign = s1_ctrl.sign;
  assign mul_mix  = s1_ctrl.mix;

  // ---------------- S2: result register ----------------
  // The high half is taken verbatim; the multiplier already produced the
  // correctly signed 2*SIZE product for the selected mode.
  assign sel_half = s1_ctrl.hi_sel ? mul_y[2*SIZE-1:SIZE] : mul_y[SIZE-1:0];
  assign s2_d     = {sel_half, s1_tag};

  // An S2 entry is retired by rsp_fire unless s2_adv refills it the same
  // edge; the load-over-drop priority in the slice gives exactly that.
  mul_pipe_reg #(.W(S2_W)) u_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (s2_adv),
    .drop  (rsp_fire),
    .d     (s2_d),
    .valid (s2_valid),
    .q     (s2_q)
  );

  assign rsp_valid = s2_valid;
  assign rsp_data  = s2_q[S2_W-1 -: SIZE];
  assign rsp_tag   = s2_q[TAG_W-1:0];

endmodule

// File: tb/tb_mul_issue_stage.sv
module tb_mul_issue_stage;

  localparam int SIZE  = 32;
  localparam int TAG_W = 5;
  localparam int EW    = SIZE + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'b00;
  logic [SIZE-1:0]   req_a = '0;
  logic [SIZE-1:0]   req_b = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [SIZE-1:0]   mul_a;
  logic [SIZE-1:0]   mul_b;
  logic              mul_sign;
  logic              mul_mix;
  logic [2*SIZE-1:0] mul_y;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [SIZE-1:0]   rsp_data;
  logic [TAG_W-1:0]  rsp_tag;

  mul_issue_stage #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_sign  (mul_sign),
    .mul_mix   (mul_mix),
    .mul_y     (mul_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag)
  );

  // Behavioural stand-in for the external array multiplier:
  // sign -> a,b signed; mix -> a signed, b unsigned; else both unsigned.
  logic [2*SIZE-1:0] ma_ext, mb_ext;
  always_comb begin
    ma_ext = {{SIZE{(mul_sign | mul_mix) & mul_a[SIZE-1]}}, mul_a};
    mb_ext = {{SIZE{mul_sign & mul_b[SIZE-1]}}, mul_b};
  end
  assign mul_y = ma_ext * mb_ext;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [EW-1:0] exp_q[$];

  // Reference result straight from the ISA definition of each opcode.
  function automatic logic [SIZE-1:0] ref_result(input logic [1:0] op,
                                                  input logic [SIZE-1:0] a,
                                                  input logic [SIZE-1:0] b);
    logic [2*SIZE-1:0] xa, xb, p;
    case (op)
      2'b01: begin xa = {{SIZE{a[SIZE-1]}}, a}; xb = {{SIZE{b[SIZE-1]}}, b}; end
      2'b10: begin xa = {{SIZE{a[SIZE-1]}}, a}; xb = {{SIZE{1'b0}}, b}; end
      default: begin xa = {{SIZE{1'b0}}, a}; xb = {{SIZE{1'b0}}, b}; end
    endcase
    p = xa * xb;
    return (op == 2'b00) ? p[SIZE-1:0] : p[2*SIZE-1:SIZE];
  endfunction

  // Response monitor: sampled on the falling edge, when every input and
  // output is stable for the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got data=%h tag=%0d, expected no response",
                 rsp_data, rsp_tag);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        delivered++;
        if ({rsp_data, rsp_tag} !== e) begin
          errors++;
          $display("FAIL rsp_data_tag: got data=%h tag=%0d, expected data=%h tag=%0d",
                   rsp_data, rsp_tag, e[EW-1:TAG_W], e[TAG_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [SIZE-1:0] a,
                      input logic [SIZE-1:0] b, input logic [TAG_W-1:0] tag);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    for (int n = 0; n < 60 && !acc; n++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc) exp_q.push_back({ref_result(op, a, b), tag});
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready got 0 for 60 cycles, expected 1 (tag %0d)", tag);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_tag, mul_a, mul_b, mul_sign, mul_mix} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rv=%b data=%h a=%h b=%h, expected all 0",
               req_ready, rsp_valid, rsp_data, mul_a, mul_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b rv=%b, expected ready=1 rv=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_latency();
    rsp_ready = 1'b1;
    send(2'b00, 32'd7, 32'd6, 5'd9);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got rsp_valid=%b one edge after accept, expected 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000002A || rsp_tag !== 5'd9) begin
      errors++;
      $display("FAIL latency_mul: got rv=%b data=%h tag=%0d, expected rv=1 data=0000002a tag=9",
               rsp_valid, rsp_data, rsp_tag);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_opcodes();
    rsp_ready = 1'b1;
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1); // MULH  -> 00000000
    send(2'b01, 32'h80000000, 32'h80000000, 5'd2); // MULH  -> 40000000
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3); // MULHU -> FFFFFFFE
    send(2'b10, 32'hFFFFFFFF, 32'd2,        5'd4); // MULHSU-> FFFFFFFF
    send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5); // MUL   -> 00000001
    send(2'b10, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd6); // MULHSU positive a
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int d0;
    rsp_ready = 1'b1;
    d0 = delivered;
    // One response per cycle: 8 sends complete in 8 edges, so at most the
    // last two are still in flight when the loop returns.
    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(10 + i));
    checks++;
    if (exp_q.size() > 2) begin
      errors++;
      $display("FAIL b2b_bubbles: got %0d outstanding, expected <= 2", exp_q.size());
    end
    wait_drain();
    checks++;
    if (delivered - d0 != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses, expected 8", delivered - d0);
    end
  endtask

  task automatic test_stall();
    int d0;
    d0 = delivered;
    rsp_ready = 1'b0;
    send(2'b00, 32'd3, 32'd5, 5'd1);
    send(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 5'd1 || rsp_data !== 32'd15) begin
        errors++;
        $display("FAIL stall_hold: got ready=%b rv=%b tag=%0d data=%h, expected ready=0 rv=1 tag=1 data=0000000f",
                 req_ready, rsp_valid, rsp_tag, rsp_data);
      end
    end
    @(posedge clk); #1;
    fork
      begin
        send(2'b01, 32'hFFFF0000, 32'h00010000, 5'd3);
        send(2'b10, 32'h80000001, 32'hF0000000, 5'd4);
      end
      begin
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (delivered - d0 != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d responses, expected 4", delivered - d0);
    end
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0;
    send(2'b00, 32'd11, 32'd12, 5'd20);
    send(2'b00, 32'd13, 32'd14, 5'd21);
    // Flush with a request on the same cycle.
    flush = 1'b1;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd99; req_b = 32'd99; req_tag = 5'd22;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got req_ready=%b during flush, expected 0", req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_kill: got rsp_valid=%b tag=%0d after flush, expected 0", rsp_valid, rsp_tag);
      end
    end
    @(posedge clk); #1;
    send(2'b11, 32'h00000010, 32'h10000000, 5'd23);
    wait_drain();
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0;
    send(2'b01, 32'h80000000, 32'h7FFFFFFF, 5'd30); // goes to S2
    send(2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd31); // sits in S1, sign=1
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req_ready, mul_a, mul_b, mul_sign, mul_mix, rsp_data, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_midop: got rv=%b ready=%b a=%h b=%h sign=%b data=%h, expected all 0",
               rsp_valid, req_ready, mul_a, mul_b, mul_sign, rsp_data);
    end
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_stale: got rv=%b ready=%b after release, expected rv=0 ready=1",
                 rsp_valid, req_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit done;
    int d0;
    logic [SIZE-1:0] a, b;
    done = 1'b0;
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          a = $urandom; b = $urandom;
          if ($urandom_range(0, 3) == 0) a = 32'h80000000;
          if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
          send(2'($urandom_range(0, 3)), a, b, 5'(i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain();
    checks++;
    if (delivered - d0 != 30) begin
      errors++;
      $display("FAIL random_count: got %0d responses, expected 30", delivered - d0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_opcodes();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_midop();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past 200000 time units, expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
